led_pwm_driver: RTL and testbench
=================================

// Module: led_pwm_driver
// PURPOSE
//  Parametrised multi-channel LED driver, successor to the free-running counter blinker.
//  Per channel: OFF / STATIC / BLINK / BREATHE mode with PWM brightness, configured over a
//  valid/ready write port. Sits between the SB_HFOSC-clocked core logic and the RGB/aux LED pins.
//  Config writes are shadowed and committed only at PWM frame boundaries (glitch-free).
// PARAMETERS
//  NUM_CH      5   number of LED channels
//  PWM_BITS    8   PWM counter/duty width; frame = 2^PWM_BITS PWM slots
//  PRESCALE    16  clk cycles per PWM slot (>=1); frame = PRESCALE*2^PWM_BITS cycles
//  BLINK_BITS  8   frame counter width for blink; blink period = 2^BLINK_BITS frames
//  ACTIVE_LOW  1   1: pin driven low when LED lit; 0: high when lit
// PORTS
//  clk         in   1                  system clock (single domain)
//  rst_n       in   1                  async reset, active low
//  cfg_valid   in   1                  config write request
//  cfg_ready   out  1                  config slot free
//  cfg_ch      in   $clog2(NUM_CH)     target channel (width >=1)
//  cfg_mode    in   2                  00 OFF, 01 STATIC, 10 BLINK, 11 BREATHE
//  cfg_duty    in   PWM_BITS           brightness / breathe peak
//  frame_tick  out  1                  1-cycle pulse on last cycle of each PWM frame
//  led_o       out  NUM_CH             LED pins, polarity per ACTIVE_LOW
// BEHAVIOUR
//  Interface: one clock clk; reset rst_n asynchronous, active low.
//  Reset (immediate, also mid-operation): all counters 0, all modes OFF, duty/level 0,
//   direction UP, cfg_ready=1, frame_tick=0, led_o={NUM_CH{ACTIVE_LOW}} (all dark).
//  Prescaler 0..PRESCALE-1; slot tick when =PRESCALE-1. pwm_cnt += 1 per tick, wraps max->0.
//  frame_tick=1 when tick && pwm_cnt==2^PWM_BITS-1; first pulse at cycle PRESCALE*2^PWM_BITS-1.
//  blink_cnt += 1 per frame_tick, wraps; blink_on = ~blink_cnt[MSB].
//  lit[i]: OFF 0; STATIC pwm_cnt<eff_duty; BLINK (pwm_cnt<eff_duty)&blink_on; BREATHE pwm_cnt<eff_level.
//   duty 0 never lit; duty max lit 2^PWM_BITS-1 of 2^PWM_BITS slots.
//  led_o registered: led_o[i]=lit[i]^ACTIVE_LOW, 1 cycle after pwm_cnt changes.
//  Handshake: accept when cfg_valid&&cfg_ready; captured into single shadow; cfg_ready=0 next
//   cycle. Shadow commits on first frame_tick strictly after accept cycle (accept coincident
//   with frame_tick commits at following frame). cfg_ready=1 cycle after commit.
//  cfg_ch>=NUM_CH: accepted, discarded, cfg_ready stays 1.
//  Breathe FSM per channel {UP,DOWN}, level PWM_BITS wide, updated at frame_tick:
//   UP: level==duty -> DOWN (level-1 if duty>0) else level+1.
//   DOWN: level==0 -> UP (level+1 if duty>0) else level-1. duty==0: level stays 0.
//  Commit with mode BREATHE from other mode: level=0, UP. Commit of duty<level while
//   BREATHE: level=new duty, DOWN. Level never exceeds duty; no wrap.
// CONFIGURATION
//  LED_PWM_GAMMA_EN defined: eff_x=(x*x)>>PWM_BITS (2*PWM_BITS-bit product) for duty and level.
//  Undefined: eff_x=x (linear). Timing, handshake, FSM identical in both builds.
// TESTING (bench: NUM_CH=2, PWM_BITS=4, PRESCALE=2, BLINK_BITS=2, ACTIVE_LOW=1; frame=32 cyc)
//  1 reset, release -> led_o=2'b11, cfg_ready=1; frame_tick at cycles 31,63,95; assert rst_n
//    mid-frame -> led_o=2'b11 same cycle, counters 0.
//  2 write ch0 STATIC duty 4 -> after next frame_tick ch0 low 8 cyc/frame, ch1 stays 1;
//    duty 15 -> low 30/32; duty 0 -> never low.
//  3 write, hold 2nd cfg_valid -> cfg_ready 0 until 1 cyc after frame_tick, 2nd accepted then;
//    write cfg_ch=3 -> no change, cfg_ready stays 1; accept on frame_tick cycle -> commit next frame.
//  4 ch1 BLINK duty 15 -> 2 frames lit 30/32 cyc, 2 frames dark, repeating per blink_cnt MSB.
//  5 ch0 BREATHE duty 3 -> lit cyc/frame 0,2,4,6,4,2,0,2...; rewrite duty 1 at level 3
//    -> level 1, DOWN; BREATHE duty 0 -> always dark.
//  6 LED_PWM_GAMMA_EN: STATIC duty 8 -> eff 4 -> lit 8 cyc/frame; duty 15 -> eff 14 -> 28 cyc.

Source files
------------

// File: rtl/led_pwm_driver_if.sv
// Config write port for led_pwm_driver.
//   cfg_valid  master->slave  write request
//   cfg_ready  slave->master  shadow slot free
//   cfg_ch     master->slave  target channel
//   cfg_mode   master->slave  00 OFF, 01 STATIC, 10 BLINK, 11 BREATHE
//   cfg_duty   master->slave  brightness / breathe peak
interface led_pwm_driver_if #(
  parameter int NUM_CH   = 5,
  parameter int PWM_BITS = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                cfg_valid;
  logic                cfg_ready;
  logic [CH_W-1:0]     cfg_ch;
  logic [1:0]          cfg_mode;
  logic [PWM_BITS-1:0] cfg_duty;

  modport master (output cfg_valid, cfg_ch, cfg_mode, cfg_duty, input  cfg_ready);
  modport slave  (input  cfg_valid, cfg_ch, cfg_mode, cfg_duty, output cfg_ready);
endinterface

// File: rtl/led_pwm_driver.sv
// Multi-channel LED PWM driver: OFF / STATIC / BLINK / BREATHE per channel.
// Config writes land in a single shadow and commit at the next PWM frame
// boundary, so a channel never changes mid-frame.
//
// Optional build macro: LED_PWM_GAMMA_EN -- square-law brightness,
//   eff = (x*x) >> PWM_BITS, applied to duty and breathe level.
//
// led_pwm_lane ports:
//   clk, rst_n      clock, async active-low reset
//   frame_tick      last cycle of the PWM frame
//   commit          shadow targets this lane and is committing now
//   new_mode/duty   shadow contents
//   pwm_cnt         shared PWM slot counter
//   blink_on        shared blink phase
//   led             registered pin, polarity per ACTIVE_LOW
//
// led_pwm_driver ports:
//   clk, rst_n      clock, async active-low reset
//   cfg             config write port (slave modport)
//   frame_tick      1-cycle pulse on the last cycle of each PWM frame
//   led_o           LED pins, dark = ACTIVE_LOW

module led_pwm_lane #(
  parameter int PWM_BITS   = 8,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_tick,
  input  logic                commit,
  input  logic                blink_on,
  input  logic [1:0]          new_mode,
  input  logic [PWM_BITS-1:0] new_duty,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led
);
  localparam logic [1:0] M_OFF     = 2'b00;
  localparam logic [1:0] M_STATIC  = 2'b01;
  localparam logic [1:0] M_BLINK   = 2'b10;
  localparam logic [1:0] M_BREATHE = 2'b11;

  typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

  logic [1:0]          mode;
  logic [PWM_BITS-1:0] duty, level;
  dir_t                dir;

  logic [PWM_BITS-1:0] step_peak, nxt_level, eff_duty, eff_level;
  dir_t                nxt_dir;
  logic                lit;

  // One breathe step. When committing, the step runs against the new peak.
  always_comb begin
    step_peak = commit ? new_duty : duty;
    nxt_dir   = dir;
    nxt_level = level;
    if (dir == UP) begin
      if (level == step_peak) begin
        nxt_dir = DOWN;
        if (step_peak != '0) nxt_level = level - 1'b1;
      end else begin
        nxt_level = level + 1'b1;
      end
    end else begin
      if (level == '0) begin
        nxt_dir = UP;
        if (step_peak != '0) nxt_level = level + 1'b1;
      end else begin
        nxt_level = level - 1'b1;
      end
    end
  end

`ifdef LED_PWM_GAMMA_EN
  logic [2*PWM_BITS-1:0] duty_sq, level_sq;
  assign duty_sq   = {{PWM_BITS{1'b0}}, duty}  * {{PWM_BITS{1'b0}}, duty};
  assign level_sq  = {{PWM_BITS{1'b0}}, level} * {{PWM_BITS{1'b0}}, level};
  assign eff_duty  = PWM_BITS'(duty_sq  >> PWM_BITS);
  assign eff_level = PWM_BITS'(level_sq >> PWM_BITS);
`else
  assign eff_duty  = duty;
  assign eff_level = level;
`endif

  // Compare is strict: duty 0 is never lit, full-scale duty misses the last slot.
  always_comb begin
    lit = 1'b0;
    case (mode)
      M_STATIC:  lit = (pwm_cnt < eff_duty);
      M_BLINK:   lit = (pwm_cnt < eff_duty) && blink_on;
      M_BREATHE: lit = (pwm_cnt < eff_level);
      default:   lit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode  <= M_OFF;
      duty  <= '0;
      level <= '0;
      dir   <= UP;
      led   <= ACTIVE_LOW;
    end else begin
      led <= lit ^ ACTIVE_LOW;
      if (commit) begin
        mode <= new_mode;
        duty <= new_duty;
        if (new_mode == M_BREATHE) begin
          if (mode != M_BREATHE) begin
            level <= '0;
            dir   <= UP;
          end else if (new_duty < level) begin
            // Clamp so the level never sits above the peak.
            level <= new_duty;
            dir   <= DOWN;
          end else begin
            level <= nxt_level;
            dir   <= nxt_dir;
          end
        end
      end else if (frame_tick && mode == M_BREATHE) begin
        level <= nxt_level;
        dir   <= nxt_dir;
      end
    end
  end
endmodule

module led_pwm_driver #(
  parameter int NUM_CH     = 5,
  parameter int PWM_BITS   = 8,
  parameter int PRESCALE   = 16,
  parameter int BLINK_BITS = 8,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  led_pwm_driver_if.slave     cfg,
  output logic                frame_tick,
  output logic [NUM_CH-1:0]   led_o
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  typedef struct packed {
    logic [CH_W-1:0]     ch;
    logic [1:0]          mode;
    logic [PWM_BITS-1:0] duty;
  } cfg_req_t;

  logic [PS_W-1:0]       presc;
  logic [PWM_BITS-1:0]   pwm_cnt;
  logic [BLINK_BITS-1:0] blink_cnt;
  logic                  slot_tick, blink_on;
  logic                  pending, accept, ch_ok;
  cfg_req_t              shadow;
  logic [NUM_CH-1:0]     commit;

  assign slot_tick  = (presc == PS_LAST);
  assign frame_tick = slot_tick && (&pwm_cnt);
  assign blink_on   = ~blink_cnt[BLINK_BITS-1];

  assign cfg.cfg_ready = ~pending;
  assign accept        = cfg.cfg_valid && ~pending;
  assign ch_ok         = ({1'b0, cfg.cfg_ch} < (CH_W+1)'(NUM_CH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc     <= '0;
      pwm_cnt   <= '0;
      blink_cnt <= '0;
      pending   <= 1'b0;
      shadow    <= '0;
    end else begin
      presc <= slot_tick ? '0 : presc + 1'b1;
      if (slot_tick)  pwm_cnt   <= pwm_cnt + 1'b1;
      if (frame_tick) blink_cnt <= blink_cnt + 1'b1;
      // Out-of-range channels are swallowed without occupying the shadow.
      // An accept on a frame_tick cycle sets pending, so it waits a full frame.
      if (accept && ch_ok) begin
        pending <= 1'b1;
        shadow  <= {cfg.cfg_ch, cfg.cfg_mode, cfg.cfg_duty};
      end else if (frame_tick) begin
        pending <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    assign commit[i] = frame_tick && pending && (shadow.ch == CH_W'(i));

    led_pwm_lane #(
      .PWM_BITS   (PWM_BITS),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .frame_tick (frame_tick),
      .commit     (commit[i]),
      .blink_on   (blink_on),
      .new_mode   (shadow.mode),
      .new_duty   (shadow.duty),
      .pwm_cnt    (pwm_cnt),
      .led        (led_o[i])
    );
  end
endmodule

// File: tb/tb_led_pwm_driver.sv
// Directed bench for led_pwm_driver (2 channels, 4-bit PWM, prescale 2,
// 32-cycle frames). Expected per-frame lit-cycle counts go into a
// scoreboard when a config is written and are checked as frames complete.
// A 3-channel instance exercises the out-of-range channel path.
module tb_led_pwm_driver;
  localparam int NUM_CH     = 2;
  localparam int PWM_BITS   = 4;
  localparam int PRESCALE   = 2;
  localparam int BLINK_BITS = 2;
  localparam bit ACTIVE_LOW = 1'b1;
  localparam int FRAME      = PRESCALE * (1 << PWM_BITS);

  localparam logic [1:0] OFF = 2'b00, STATIC = 2'b01, BLINK = 2'b10, BREATHE = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick, frame_tick3;
  logic [1:0]  led_o;
  logic [2:0]  led_o3;

  led_pwm_driver_if #(.NUM_CH(2), .PWM_BITS(PWM_BITS)) cfg ();
  led_pwm_driver_if #(.NUM_CH(3), .PWM_BITS(PWM_BITS)) cfg3 ();

  led_pwm_driver #(
    .NUM_CH(NUM_CH), .PWM_BITS(PWM_BITS), .PRESCALE(PRESCALE),
    .BLINK_BITS(BLINK_BITS), .ACTIVE_LOW(ACTIVE_LOW)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .cfg(cfg), .frame_tick(frame_tick), .led_o(led_o)
  );

  led_pwm_driver #(
    .NUM_CH(3), .PWM_BITS(PWM_BITS), .PRESCALE(PRESCALE),
    .BLINK_BITS(BLINK_BITS), .ACTIVE_LOW(ACTIVE_LOW)
  ) u_dut3 (
    .clk(clk), .rst_n(rst_n), .cfg(cfg3), .frame_tick(frame_tick3), .led_o(led_o3)
  );

  always #5 clk = ~clk;

  typedef struct { string tag; int c0; int c1; } exp_t;
  exp_t sb[$];
  int   nchk = 0;
  int   nerr = 0;
  int   cyc  = 0;

  // Lit cycles per frame for a given duty or breathe level.
  function automatic int lc(input int d);
`ifdef LED_PWM_GAMMA_EN
    return PRESCALE * ((d * d) >> PWM_BITS);
`else
    return PRESCALE * d;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic sync();
    int n = 0;
    do begin
      step();
      n++;
    end while (!frame_tick && n < 2 * FRAME);
    chk("frame_tick_seen", frame_tick, 1);
  endtask

  task automatic write(input logic ch, input logic [1:0] mode, input logic [3:0] duty);
    int n = 0;
    cfg.cfg_valid = 1'b1;
    cfg.cfg_ch    = ch;
    cfg.cfg_mode  = mode;
    cfg.cfg_duty  = duty;
    while (!cfg.cfg_ready && n < 4 * FRAME) begin
      step();
      n++;
    end
    chk("write_ready", cfg.cfg_ready, 1);
    step();
    cfg.cfg_valid = 1'b0;
  endtask

  task automatic push(input string tag, input int c0, input int c1);
    exp_t e;
    e.tag = tag;
    e.c0  = c0;
    e.c1  = c1;
    sb.push_back(e);
  endtask

  // Call on a frame_tick cycle; counts dark-pin (lit) cycles of the next frame.
  task automatic measure();
    int   c0 = 0;
    int   c1 = 0;
    exp_t e;
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (led_o[0] === 1'b0) c0++;
      if (led_o[1] === 1'b0) c1++;
    end
    chk("frame_end_tick", frame_tick, 1);
    chk("sb_nonempty", (sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, "_ch0"}, c0, e.c0);
      chk({e.tag, "_ch1"}, c1, e.c1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int f;
    int lv[8] = '{0, 1, 2, 3, 2, 1, 0, 1};

    cfg.cfg_valid  = 1'b0; cfg.cfg_ch  = '0; cfg.cfg_mode  = OFF; cfg.cfg_duty  = '0;
    cfg3.cfg_valid = 1'b0; cfg3.cfg_ch = '0; cfg3.cfg_mode = OFF; cfg3.cfg_duty = '0;

    // Reset state and frame_tick cadence.
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_led", led_o, 2'b11);
    chk("rst_ready", cfg.cfg_ready, 1);
    chk("rst_tick", frame_tick, 0);
    rst_n = 1'b1;
    cyc   = 0;
    sync(); chk("tick1_cyc", cyc, 31);
    sync(); chk("tick2_cyc", cyc, 63);
    sync(); chk("tick3_cyc", cyc, 95);

    // Out-of-range channel: swallowed, ready never drops.
    step();
    cfg3.cfg_valid = 1'b1; cfg3.cfg_ch = 2'd3; cfg3.cfg_mode = STATIC; cfg3.cfg_duty = 4'd15;
    chk("ch3_ready_before", cfg3.cfg_ready, 1);
    step();
    cfg3.cfg_valid = 1'b0;
    chk("ch3_ready_after", cfg3.cfg_ready, 1);
    sync();
    chk("ch3_tick", frame_tick3, 1);
    repeat (4) step();
    chk("ch3_led_dark", led_o3, 3'b111);

    // STATIC duty sweep.
    write(1'b0, STATIC, 4'd4);
    chk("busy_after_accept", cfg.cfg_ready, 0);
    sync(); push("static4", lc(4), 0); measure();
    step(); write(1'b0, STATIC, 4'd15);
    sync(); push("static15", lc(15), 0); measure();
    step(); write(1'b0, STATIC, 4'd0);
    sync(); push("static0", 0, 0); measure();

    // Held second request waits for the commit.
    step(); write(1'b0, STATIC, 4'd4);
    chk("busy_held", cfg.cfg_ready, 0);
    cfg.cfg_valid = 1'b1; cfg.cfg_ch = 1'b0; cfg.cfg_mode = STATIC; cfg.cfg_duty = 4'd15;
    n = 0;
    while (!frame_tick && n < 2 * FRAME) begin step(); n++; end
    chk("held_tick", frame_tick, 1);
    chk("held_ready_at_tick", cfg.cfg_ready, 0);
    step(); chk("ready_after_commit", cfg.cfg_ready, 1);
    step(); chk("second_accepted", cfg.cfg_ready, 0);
    cfg.cfg_valid = 1'b0;
    sync(); push("held15", lc(15), 0); measure();

    // Accept on the frame_tick cycle commits a frame later.
    cfg.cfg_valid = 1'b1; cfg.cfg_ch = 1'b0; cfg.cfg_mode = STATIC; cfg.cfg_duty = 4'd4;
    chk("ready_on_tick", cfg.cfg_ready, 1);
    push("tick_accept_old", lc(15), 0);
    push("tick_accept_new", lc(4), 0);
    measure();
    cfg.cfg_valid = 1'b0;
    measure();

    // BLINK: 2 frames on, 2 off, phase from frames since reset.
    step(); write(1'b1, BLINK, 4'd15);
    sync();
    for (int j = 0; j < 4; j++) begin
      f = (cyc + 1) / FRAME + j;
      push("blink15", lc(4), ((f % 4) < 2) ? lc(15) : 0);
    end
    repeat (4) measure();
    step(); write(1'b1, OFF, 4'd0);
    sync(); push("ch1_off", lc(4), 0); measure();

    // BREATHE triangle, then peak drop below the current level.
    step(); write(1'b0, BREATHE, 4'd3);
    sync();
    for (int j = 0; j < 8; j++) push("breathe3", lc(lv[j]), 0);
    repeat (8) measure();
    push("breathe3_l2", lc(2), 0); measure();
    cfg.cfg_valid = 1'b1; cfg.cfg_ch = 1'b0; cfg.cfg_mode = BREATHE; cfg.cfg_duty = 4'd1;
    push("breathe3_l3", lc(3), 0);
    push("breathe1_clamp", lc(1), 0);
    push("breathe1_a", lc(0), 0);
    push("breathe1_b", lc(1), 0);
    push("breathe1_c", lc(0), 0);
    measure();
    cfg.cfg_valid = 1'b0;
    repeat (4) measure();
    step(); write(1'b0, BREATHE, 4'd0);
    sync();
    repeat (3) push("breathe0", 0, 0);
    repeat (3) measure();

    // Mid-scale STATIC (gamma-sensitive point).
    step(); write(1'b0, STATIC, 4'd8);
    sync(); push("static8", lc(8), 0); measure();

    // Asynchronous reset mid-frame with a write pending.
    step(); write(1'b0, STATIC, 4'd15);
    sync(); push("pre_reset15", lc(15), 0); measure();
    step(); write(1'b0, STATIC, 4'd4);
    chk("pre_reset_busy", cfg.cfg_ready, 0);
    repeat (2) step();
    chk("pre_reset_lit", led_o[0], 0);
    rst_n = 1'b0;
    #1;
    chk("async_led", led_o, 2'b11);
    chk("async_ready", cfg.cfg_ready, 1);
    chk("async_tick", frame_tick, 0);
    step(); step();
    rst_n = 1'b1;
    cyc   = 0;
    sync(); chk("tick_after_reset", cyc, 31);
    push("post_reset_a", 0, 0);
    push("post_reset_b", 0, 0);
    repeat (2) measure();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
